// File: rtl/final2_soc_mem_pkg.sv
// Shared types and sizing for the on-chip RAM arbiter slice.
package final2_soc_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 2;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;
    localparam int unsigned MEM_RD_LAT = 1;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
        logic                  write;
    } mem_req_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } rr_owner_t;

endpackage

// File: rtl/final2_soc_rr_arb2.sv
// Two-input round-robin grant: combinational one-hot grant, registered last winner.
module final2_soc_rr_arb2
    import final2_soc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] gnt
);

    rr_owner_t last_grant_q, last_grant_d;

    always_comb begin
        gnt = '0;
        if (ack) begin
            unique case (req)
                2'b11:   gnt = (last_grant_q == GNT_M1) ? 2'b01 : 2'b10;
                default: gnt = req;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (|gnt) begin
            last_grant_d = gnt[1] ? GNT_M1 : GNT_M0;
        end
    end

    // Reset value points at m1 so the first contention goes to m0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_M1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/final2_soc_onchip_memory_arbiter.sv
// Two-master round-robin front end for the single-port on-chip RAM, with the
// fixed 1-cycle read-return pipeline.
module final2_soc_onchip_memory_arbiter
    import final2_soc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned BE_W       = MEM_BE_W,
    parameter int unsigned RD_LATENCY = MEM_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    generate
        if (RD_LATENCY != 1) begin : g_bad_latency
            $error("final2_soc_onchip_memory_arbiter: only RD_LATENCY = 1 is supported");
        end
        if ((DATA_W % 8) != 0 || BE_W != DATA_W / 8) begin : g_bad_lanes
            $error("final2_soc_onchip_memory_arbiter: DATA_W must be a multiple of 8 and BE_W = DATA_W/8");
        end
        if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_bad_size
            $error("final2_soc_onchip_memory_arbiter: sizes must match final2_soc_mem_pkg");
        end
    endgenerate

    mem_req_t   req0, req1, win;
    logic [1:0] req, gnt;
    logic       ack;
    logic       rd_vld_q, rd_vld_d;
    logic       rd_owner_q, rd_owner_d;

    assign req0 = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata, write: m0_write};
    assign req1 = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata, write: m1_write};
    assign req  = {m1_read | m1_write, m0_read | m0_write};

    // Reset is folded into ack so no grant leaks out while the block is held in reset.
    assign ack = ~reset & ~reset_req;

    final2_soc_rr_arb2 u_arb (
        .clk (clk),
        .rst (reset),
        .req (req),
        .ack (ack),
        .gnt (gnt)
    );

    always_comb begin
        win = '0;
        if (gnt[0]) begin
            win = req0;
        end else if (gnt[1]) begin
            win = req1;
        end
    end

    assign mem_chipselect = |gnt;
    assign mem_write      = win.write;
    assign mem_address    = win.addr;
    assign mem_byteenable = win.be;
    assign mem_writedata  = win.wdata;
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = ~gnt[0];
    assign m1_waitrequest = ~gnt[1];

    always_comb begin
        rd_vld_d   = (|gnt) & ~win.write;
        rd_owner_d = gnt[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_readdatavalid = rd_vld_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_vld_q &  rd_owner_q;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_final2_soc_onchip_memory_arbiter.sv
// Bench for the two-master RAM arbiter: directed scenarios plus random traffic
// against a transaction-level model (grant rule, shadow memory, one-deep read return).
module tb_final2_soc_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset, reset_req;
    logic [1:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [1:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    final2_soc_onchip_memory_arbiter #(
        .ADDR_W(2), .DATA_W(32), .BE_W(4), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // 4x32 RAM: registered read, byte-lane writes.
    logic [31:0] ram [4] = '{32'hC0DE0000, 32'hC0DE1111, 32'hC0DE2222, 32'hC0DE3333};
    logic [31:0] ram_q = '0;
    assign mem_readdata = ram_q;

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    // Reference model state.
    logic [31:0] shadow [4] = '{32'hC0DE0000, 32'hC0DE1111, 32'hC0DE2222, 32'hC0DE3333};
    int          last_winner = 1;
    logic        pend_vld = 1'b0;
    int          pend_owner = 0;
    logic [31:0] pend_data = '0;
    logic        g0, g1;
    int          n_tests = 0, n_fail = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check this cycle's outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic        r0, r1, ew;
        logic [1:0]  ea;
        logic [3:0]  ebe;
        logic [31:0] ed;
        @(negedge clk);
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset && !reset_req) begin
            if (r0 && r1) begin
                if (last_winner == 1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = r0;
                g1 = r1;
            end
        end
        ew = 1'b0; ea = '0; ebe = '0; ed = '0;
        if (g0) begin
            ew = m0_write; ea = m0_address; ebe = m0_byteenable; ed = m0_writedata;
        end else if (g1) begin
            ew = m1_write; ea = m1_address; ebe = m1_byteenable; ed = m1_writedata;
        end
        if (reset) pend_vld = 1'b0;
        check("m0_wait", m0_waitrequest, !g0);
        check("m1_wait", m1_waitrequest, !g1);
        check("mem_cs", mem_chipselect, g0 | g1);
        check("mem_wr", mem_write, ew);
        check("mem_addr", mem_address, ea);
        check("mem_be", mem_byteenable, ebe);
        check("mem_wdata", mem_writedata, ed);
        check("mem_clken", mem_clken, 1);
        check("m0_rdv", m0_readdatavalid, pend_vld && pend_owner == 0);
        check("m1_rdv", m1_readdatavalid, pend_vld && pend_owner == 1);
        if (pend_vld) check("rdata", (pend_owner == 0) ? m0_readdata : m1_readdata, pend_data);
        @(posedge clk);
        cyc++;
        if (reset) begin
            last_winner = 1;
            pend_vld = 1'b0;
        end else begin
            pend_vld = (g0 | g1) && !ew;
            pend_owner = g1 ? 1 : 0;
            pend_data = shadow[ea];
            if (g0 | g1) begin
                last_winner = g1 ? 1 : 0;
                if (ew)
                    for (int i = 0; i < 4; i++)
                        if (ebe[i]) shadow[ea][8*i +: 8] = ed[8*i +: 8];
            end
        end
        #1;
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic set_m0(input logic rd, input logic wr, input logic [1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic set_m1(input logic rd, input logic wr, input logic [1:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    task automatic rand_req(output logic rd, output logic wr, output logic [1:0] a,
                            output logic [3:0] be, output logic [31:0] d);
        int unsigned k;
        k  = $urandom_range(0, 5);
        rd = (k == 1 || k == 2 || k == 5);
        wr = (k == 3 || k == 4 || k == 5);
        a  = 2'($urandom_range(0, 3));
        be = 4'($urandom_range(1, 15));
        d  = $urandom;
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        #1;
        step(); step();
        reset = 1'b0;
        step();

        // Write then back-to-back read from m0.
        set_m0(0, 1, 1, 4'hF, 32'hDEADBEEF); step();
        set_m0(1, 0, 1, 4'hF, 0);            step();
        check("t1_rdv", m0_readdatavalid, 1);
        check("t1_data", m0_readdata, 32'hDEADBEEF);
        idle_all(); step();

        // Continuous contention from reset: strict alternation.
        reset = 1'b1; step(); reset = 1'b0;
        set_m0(1, 0, 0, 4'hF, 0);
        set_m1(1, 0, 2, 4'hF, 0);
        repeat (6) step();
        idle_all(); step();

        // Partial-lane write merge.
        set_m0(0, 1, 3, 4'hF, 32'h11223344); step();
        idle_all();
        set_m1(0, 1, 3, 4'h2, 32'h0000AA00); step();
        idle_all();
        set_m0(1, 0, 3, 4'hF, 0); step();
        check("t3_data", m0_readdata, 32'h1122AA44);
        idle_all(); step();

        // reset_req stalls grants; the read already granted still returns.
        set_m0(1, 0, 0, 4'hF, 0);
        set_m1(1, 0, 2, 4'hF, 0);
        step();
        reset_req = 1'b1; repeat (3) step();
        reset_req = 1'b0; repeat (2) step();
        idle_all(); step();

        // Reset right after a read grant drops that read.
        set_m0(1, 0, 1, 4'hF, 0); step();
        idle_all(); reset = 1'b1; step();
        check("t5_rdv", m0_readdatavalid, 0);
        reset = 1'b0;
        set_m0(1, 0, 0, 4'hF, 0);
        set_m1(1, 0, 2, 4'hF, 0);
        #2;
        check("t5_first", m0_waitrequest, 0);
        step(); step();
        idle_all(); step();

        // Read and write together is a write.
        set_m1(1, 1, 2, 4'hF, 32'h5); step();
        idle_all(); step();
        set_m0(1, 0, 2, 4'hF, 0); step();
        check("t6_data", m0_readdata, 32'h5);
        idle_all(); step();

        // Random traffic; a master holds its request until the model grants it.
        for (int n = 0; n < 400; n++) begin
            if (g0 || !(m0_read | m0_write))
                rand_req(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (g1 || !(m1_read | m1_write))
                rand_req(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
            reset_req = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0; reset_req = 1'b0; idle_all();
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
